// File: rtl/fb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fb_mem_arbiter
//  Brief    : Single-port frame buffer arbiter. It merges a buffered,
//             high-priority camera write stream with a starvation-guarded
//             reader, and runs the capture/hand-off frame FSM.
//  Revision : 1.0 - initial release
// ============================================================================
module fb_mem_arbiter #(
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 8,
    parameter int WB_DEPTH  = 4,
    parameter int RD_STARVE = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_start,
    input  logic              cam_vsync,
    input  logic              cam_wr,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_din,
    output logic              cam_overflow,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_done,
    output logic              mem_wr,
    output logic              img_req,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int c_PTR_W = $clog2(WB_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STV_W = $clog2(RD_STARVE + 1);

    localparam logic [c_CNT_W-1:0] c_DEPTH      = c_CNT_W'(WB_DEPTH);
    localparam logic [c_STV_W-1:0] c_STARVE_MAX = c_STV_W'(RD_STARVE);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ARM     = 3'd1;
    localparam logic [2:0] c_ST_CAPTURE = 3'd2;
    localparam logic [2:0] c_ST_DRAIN   = 3'd3;
    localparam logic [2:0] c_ST_HOLD    = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               w_img_set;
    logic               r_img_req;

    logic [ADDR_W-1:0]  r_wb_addr [WB_DEPTH];
    logic [DATA_W-1:0]  r_wb_data [WB_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_STV_W-1:0] r_starve;
    logic               r_overflow;

    logic               w_wb_nonempty;
    logic               w_wr_sel;
    logic               w_rd_gnt;
    logic               w_cam_in;
    logic               w_push;
    logic               w_drop;
    logic               w_arm_to_cap;

    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_din;
    logic               r_mem_we;
    logic               r_mem_en;
    logic               r_rd_p1;
    logic               r_rd_p2;
    logic               r_rd_valid;
    logic [DATA_W-1:0]  r_rd_data;

    // Arbitration: buffered writes win unless the reader has been starved.
    assign w_wb_nonempty = (r_count != '0);
    assign w_wr_sel      = w_wb_nonempty && (!rd_req || (r_starve < c_STARVE_MAX));
    assign w_rd_gnt      = rd_req && !w_wr_sel && !reset;
    assign w_cam_in      = (r_state == c_ST_CAPTURE) && cam_wr;
    assign w_push        = w_cam_in && ((r_count != c_DEPTH) || w_wr_sel);
    assign w_drop        = w_cam_in && !w_push;
    assign w_arm_to_cap  = (r_state == c_ST_ARM) && cam_vsync;

    always_comb begin
        w_state_nxt = r_state;
        w_img_set   = 1'b0;
        case (r_state)
            c_ST_IDLE:    if (cap_start) w_state_nxt = c_ST_ARM;
            c_ST_ARM:     if (cam_vsync) w_state_nxt = c_ST_CAPTURE;
            c_ST_CAPTURE: if (cam_vsync) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: begin
                if (!w_wb_nonempty && !w_wr_sel) begin
                    w_state_nxt = c_ST_HOLD;
                    w_img_set   = 1'b1;
                end
            end
            c_ST_HOLD:    if (rd_done) w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_img_req <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_img_req <= w_img_set;
        end
    end

    // Entry storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_wb_addr[r_wr_ptr] <= cam_addr;
            r_wb_data[r_wr_ptr] <= cam_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_wr_sel)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_wr_sel)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_wr_sel)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_arm_to_cap)
            r_overflow <= 1'b0;
        else if (w_drop)
            r_overflow <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || !rd_req || w_rd_gnt)
            r_starve <= '0;
        else if (w_wr_sel && (r_starve != c_STARVE_MAX))
            r_starve <= r_starve + 1'b1;
    end

    // SRAM command stage; address and data hold on idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else begin
            r_mem_en <= w_wr_sel || w_rd_gnt;
            r_mem_we <= w_wr_sel;
            if (w_wr_sel) begin
                r_mem_addr <= r_wb_addr[r_rd_ptr];
                r_mem_din  <= r_wb_data[r_rd_ptr];
            end else if (w_rd_gnt) begin
                r_mem_addr <= rd_addr;
            end
        end
    end

    // Read return pipeline: grant -> command -> SRAM data -> registered data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_p1    <= 1'b0;
            r_rd_p2    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_p1    <= w_rd_gnt;
            r_rd_p2    <= r_rd_p1;
            r_rd_valid <= r_rd_p2;
            if (r_rd_p2)
                r_rd_data <= mem_dout;
        end
    end

    assign cam_overflow = r_overflow;
    assign rd_gnt       = w_rd_gnt;
    assign rd_valid     = r_rd_valid;
    assign rd_data      = r_rd_data;
    assign mem_wr       = !reset && (w_wb_nonempty || cam_wr);
    assign img_req      = r_img_req;
    assign busy         = (r_state != c_ST_IDLE);
    assign mem_addr     = r_mem_addr;
    assign mem_din      = r_mem_din;
    assign mem_we       = r_mem_we;
    assign mem_en       = r_mem_en;

endmodule
`default_nettype wire

// File: tb/tb_fb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fb_mem_arbiter
//  Brief    : Directed self-checking bench for fb_mem_arbiter with an SRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset, cap_start, cam_vsync, cam_wr, rd_req, rd_done;
    logic [16:0] cam_addr, rd_addr, mem_addr;
    logic [7:0]  cam_din, rd_data, mem_din, mem_dout;
    logic        cam_overflow, rd_gnt, rd_valid, mem_wr, img_req, busy, mem_we, mem_en;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    fb_mem_arbiter #(
        .ADDR_W(17), .DATA_W(8), .WB_DEPTH(4), .RD_STARVE(8)
    ) u_dut (
        .clk(clk), .reset(reset), .cap_start(cap_start), .cam_vsync(cam_vsync),
        .cam_wr(cam_wr), .cam_addr(cam_addr), .cam_din(cam_din),
        .cam_overflow(cam_overflow), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
        .mem_wr(mem_wr), .img_req(img_req), .busy(busy), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_we(mem_we), .mem_en(mem_en), .mem_dout(mem_dout)
    );

    // Synchronous SRAM: read data appears the cycle after mem_en.
    logic [7:0] sram [0:131071];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_din;
            else        mem_dout       <= sram[mem_addr];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [16:0] wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    int          wr_cyc_q  [$];
    int          img_cyc_q [$];
    int          val_cyc_q [$];
    logic [7:0]  val_data_q[$];

    always @(negedge clk) begin
        if (mem_en && mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_din);
            wr_cyc_q.push_back(cyc);
        end
        if (img_req) img_cyc_q.push_back(cyc);
        if (rd_valid) begin
            val_cyc_q.push_back(cyc);
            val_data_q.push_back(rd_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        img_cyc_q.delete(); val_cyc_q.delete(); val_data_q.delete();
    endtask

    task automatic pulse_cap();
        cap_start = 1'b1; step(); cap_start = 1'b0;
    endtask

    task automatic pulse_vsync();
        cam_vsync = 1'b1; step(); cam_vsync = 1'b0;
    endtask

    task automatic finish_frame();
        int n0;
        int k;
        n0 = img_cyc_q.size();
        pulse_vsync();
        k = 0;
        while (img_cyc_q.size() == n0 && k < 64) begin step(); k++; end
        vecs++;
        if (img_cyc_q.size() == n0) begin
            errs++;
            $display("FAIL frame_img_req: got no pulse, expected one within 64 cycles");
        end
        step();
        rd_done = 1'b1; step(); rd_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run(2);
        @(negedge clk);
        vecs++;
        if ({rd_gnt, rd_valid, mem_wr, img_req, busy, mem_we, mem_en, cam_overflow} !== 8'h00) begin
            errs++;
            $display("FAIL reset_flags: got %b expected 00000000",
                     {rd_gnt, rd_valid, mem_wr, img_req, busy, mem_we, mem_en, cam_overflow});
        end
        vecs++;
        if ({mem_addr, mem_din, rd_data} !== 33'h0) begin
            errs++;
            $display("FAIL reset_buses: got %h expected 0", {mem_addr, mem_din, rd_data});
        end
        step();
        reset = 1'b0;
        step();
        // Mid-capture reset with two bytes left in the write buffer.
        pulse_cap();
        pulse_vsync();
        clear_logs();
        rd_req  = 1'b1;
        rd_addr = 17'h01000;
        for (int t = 0; t < 10; t++) begin
            cam_wr   = 1'b1;
            cam_addr = 17'(32'h40 + t);
            cam_din  = 8'(8'h50 + t);
            step();
        end
        cam_wr = 1'b0;
        rd_req = 1'b0;
        vecs++;
        if (wr_addr_q.size() != 8) begin
            errs++;
            $display("FAIL reset_setup_writes: got %0d expected 8", wr_addr_q.size());
        end
        clear_logs();
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        @(negedge clk);
        vecs++;
        if ({busy, mem_wr, mem_en, cam_overflow, img_req} !== 5'b0) begin
            errs++;
            $display("FAIL reset_midframe_state: got %b expected 00000",
                     {busy, mem_wr, mem_en, cam_overflow, img_req});
        end
        run(20);
        vecs++;
        if (wr_addr_q.size() != 0 || img_cyc_q.size() != 0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_no_flush: got writes=%0d img=%0d busy=%b expected 0 0 0",
                     wr_addr_q.size(), img_cyc_q.size(), busy);
        end
    endtask

    task automatic test_basic_frame();
        int k;
        clear_logs();
        pulse_cap();
        @(negedge clk);
        vecs++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL frame_busy_arm: got %b expected 1", busy);
        end
        step();
        pulse_vsync();
        // Last byte coincides with the closing vsync and must still land.
        for (int i = 0; i < 16; i++) begin
            cam_wr    = 1'b1;
            cam_addr  = 17'(i);
            cam_din   = 8'(8'hA0 + i);
            cam_vsync = (i == 15);
            step();
        end
        cam_wr    = 1'b0;
        cam_vsync = 1'b0;
        k = 0;
        while (img_cyc_q.size() == 0 && k < 40) begin step(); k++; end
        vecs++;
        if (img_cyc_q.size() == 0) begin
            errs++;
            $display("FAIL frame_img_timeout: got no img_req expected one within 40 cycles");
        end
        vecs++;
        if (wr_addr_q.size() != 16) begin
            errs++;
            $display("FAIL frame_write_count: got %0d expected 16", wr_addr_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            if (i < wr_addr_q.size()) begin
                vecs++;
                if ({wr_addr_q[i], wr_data_q[i]} !== {17'(i), 8'(8'hA0 + i)}) begin
                    errs++;
                    $display("FAIL frame_write_%0d: got addr=%h data=%h expected addr=%h data=%h",
                             i, wr_addr_q[i], wr_data_q[i], 17'(i), 8'(8'hA0 + i));
                end
            end
        end
        if (wr_cyc_q.size() == 16 && img_cyc_q.size() != 0) begin
            vecs++;
            if (img_cyc_q[0] != wr_cyc_q[15] + 1) begin
                errs++;
                $display("FAIL frame_img_timing: got cycle %0d expected %0d",
                         img_cyc_q[0], wr_cyc_q[15] + 1);
            end
        end
        run(5);
        vecs++;
        if (img_cyc_q.size() != 1 || busy !== 1'b1) begin
            errs++;
            $display("FAIL frame_hold: got img=%0d busy=%b expected 1 1", img_cyc_q.size(), busy);
        end
        rd_done = 1'b1; step(); rd_done = 1'b0;
        @(negedge clk);
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL frame_done_idle: got busy=%b expected 0", busy);
        end
        step();
    endtask

    task automatic test_read_latency();
        int g;
        g = 0;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            rd_req  = 1'b1;
            rd_addr = 17'(5 + i);
            @(negedge clk);
            if (i == 0) g = cyc;
            vecs++;
            if (rd_gnt !== 1'b1) begin
                errs++;
                $display("FAIL read_gnt_%0d: got %b expected 1", i, rd_gnt);
            end
            step();
        end
        rd_req = 1'b0;
        run(6);
        vecs++;
        if (val_cyc_q.size() != 4 || wr_addr_q.size() != 0) begin
            errs++;
            $display("FAIL read_valid_count: got valid=%0d writes=%0d expected 4 0",
                     val_cyc_q.size(), wr_addr_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < val_cyc_q.size()) begin
                vecs++;
                if (val_cyc_q[i] != g + 3 + i || val_data_q[i] !== 8'(8'hA5 + i)) begin
                    errs++;
                    $display("FAIL read_data_%0d: got cyc=%0d data=%h expected cyc=%0d data=%h",
                             i, val_cyc_q[i], val_data_q[i], g + 3 + i, 8'(8'hA5 + i));
                end
            end
        end
    endtask

    task automatic test_starvation();
        logic exp_gnt;
        clear_logs();
        pulse_cap();
        pulse_vsync();
        rd_req  = 1'b1;
        rd_addr = 17'h00003;
        for (int t = 0; t < 19; t++) begin
            cam_wr   = 1'b1;
            cam_addr = 17'(32'h100 + t);
            cam_din  = 8'(t);
            @(negedge clk);
            exp_gnt = (t == 0 || t == 9 || t == 18);
            vecs++;
            if (rd_gnt !== exp_gnt) begin
                errs++;
                $display("FAIL starve_gnt_t%0d: got %b expected %b", t, rd_gnt, exp_gnt);
            end
            step();
        end
        cam_wr = 1'b0;
        rd_req = 1'b0;
        run(6);
        vecs++;
        if (wr_addr_q.size() != 19 || cam_overflow !== 1'b0) begin
            errs++;
            $display("FAIL starve_writes: got writes=%0d ovf=%b expected 19 0",
                     wr_addr_q.size(), cam_overflow);
        end
        vecs++;
        if (val_data_q.size() != 3 || (val_data_q.size() == 3 && val_data_q[2] !== 8'hA3)) begin
            errs++;
            $display("FAIL starve_reads: got count=%0d expected 3 reads of a3", val_data_q.size());
        end
        finish_frame();
    endtask

    task automatic test_overflow();
        logic exp_ovf;
        logic seq_ok;
        clear_logs();
        pulse_cap();
        pulse_vsync();
        rd_addr = 17'h00003;
        // Each reader slot nets one extra entry; the fifth slot finds the buffer full.
        for (int t = 0; t < 40; t++) begin
            cam_wr   = (t < 37);
            rd_req   = (t < 37);
            cam_addr = 17'(32'h200 + t);
            cam_din  = 8'(t);
            @(negedge clk);
            exp_ovf = (t >= 37);
            vecs++;
            if (cam_overflow !== exp_ovf) begin
                errs++;
                $display("FAIL ovf_t%0d: got %b expected %b", t, cam_overflow, exp_ovf);
            end
            step();
        end
        cam_wr = 1'b0;
        rd_req = 1'b0;
        run(4);
        seq_ok = (wr_data_q.size() == 36);
        for (int i = 0; i < wr_data_q.size(); i++)
            if (wr_data_q[i] !== 8'(i)) seq_ok = 1'b0;
        vecs++;
        if (!seq_ok) begin
            errs++;
            $display("FAIL ovf_kept_bytes: got %0d writes expected 36 in order 0..35", wr_data_q.size());
        end
        finish_frame();
        pulse_cap();
        @(negedge clk);
        vecs++;
        if (cam_overflow !== 1'b1) begin
            errs++;
            $display("FAIL ovf_sticky_arm: got %b expected 1", cam_overflow);
        end
        step();
        pulse_vsync();
        @(negedge clk);
        vecs++;
        if (cam_overflow !== 1'b0) begin
            errs++;
            $display("FAIL ovf_clear_capture: got %b expected 0", cam_overflow);
        end
        step();
        finish_frame();
    endtask

    task automatic test_gating();
        clear_logs();
        cam_addr = 17'h00300;
        cam_din  = 8'h11;
        cam_wr = 1'b1; run(3); cam_wr = 1'b0;
        pulse_cap();
        cam_wr = 1'b1; run(2); cam_wr = 1'b0;
        pulse_vsync();
        rd_done = 1'b1; step(); rd_done = 1'b0;
        @(negedge clk);
        vecs++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL gate_rd_done_capture: got busy=%b expected 1", busy);
        end
        step();
        cam_wr   = 1'b1;
        cam_addr = 17'h003FF;
        cam_din  = 8'h77;
        step();
        cam_wr   = 1'b0;
        cam_addr = 17'h00300;
        cam_din  = 8'h11;
        pulse_vsync();
        cam_wr = 1'b1;
        step();
        cap_start = 1'b1; step(); cap_start = 1'b0;
        step();
        cam_wr  = 1'b0;
        rd_done = 1'b1; step(); rd_done = 1'b0;
        @(negedge clk);
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL gate_cap_start_hold: got busy=%b expected 0", busy);
        end
        run(3);
        vecs++;
        if (wr_addr_q.size() != 1 || (wr_addr_q.size() == 1 &&
            {wr_addr_q[0], wr_data_q[0]} !== {17'h003FF, 8'h77})) begin
            errs++;
            $display("FAIL gate_writes: got %0d writes expected 1 write 3ff=77", wr_addr_q.size());
        end
        vecs++;
        if (cam_overflow !== 1'b0 || img_cyc_q.size() != 1) begin
            errs++;
            $display("FAIL gate_flags: got ovf=%b img=%0d expected 0 1", cam_overflow, img_cyc_q.size());
        end
    endtask

    initial begin
        reset     = 1'b1;
        cap_start = 1'b0;
        cam_vsync = 1'b0;
        cam_wr    = 1'b0;
        cam_addr  = '0;
        cam_din   = '0;
        rd_req    = 1'b0;
        rd_addr   = '0;
        rd_done   = 1'b0;
        test_reset();
        test_basic_frame();
        test_read_latency();
        test_starvation();
        test_overflow();
        test_gating();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
